ifetch_unit: RTL and testbench

Instruction fetch unit for the 5-stage pipeline: consumes the fetch address PCF produced by the PC stage and issues it to the instruction-memory port over a req/ready + rvalid handshake. It loads the returned word into the IF/ID pipeline register. It asserts FetchStallF back to the hazard unit whenever no instruction retires into decode this cycle, holding PCF stable. It honours decode stall/flush and discards in-flight responses made stale by a redirect.

---
 rtl/ifetch_unit.sv | 139 +++++++++++++
 tb/tb_ifetch_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage for the 5-stage pipeline.
// Issues PCF to imem over a req/ready + rvalid handshake and loads the
// returned word into the IF/ID register (InstrD, PCPlus4D, ValidD, AdelD).
// Ports: clk, reset_n (sync, active-low), PCF, StallD, FlushD,
//   imem_req/imem_addr/imem_ready/imem_rvalid/imem_rdata, FetchStallF,
//   InstrD, PCPlus4D, ValidD, AdelD.
// Optional: IFETCH_ALIGN_CHECK_EN traps misaligned PCF as an AdelD marker.
module ifetch_unit #(
  parameter logic [31:0] RESET_INSTR = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] PCF,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        FetchStallF,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        AdelD
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]  state;
  logic [31:0] req_addr;
  logic [31:0] hold_instr;
  logic        discard;
  logic        mis;
  logic        accept;
  logic        rsp;
  logic        wr_mem;
  logic        wr_hold;
  logic        wr_adel;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign mis = (state == REQ) && (PCF[1:0] != 2'b00);
`else
  logic unused_pcf_lo;
  assign unused_pcf_lo = ^PCF[1:0];
  assign mis = 1'b0;
`endif

  assign imem_req  = (state == REQ) && !mis;
  assign imem_addr = {PCF[31:2], 2'b00};
  assign accept    = imem_req && imem_ready;
  assign rsp       = (state == WAIT) && imem_rvalid;

  // A response tagged by an earlier redirect never reaches IF/ID.
  assign wr_mem  = rsp && !discard && !FlushD && !StallD;
  assign wr_hold = (state == HOLD) && !FlushD && !StallD;
  assign wr_adel = mis && !FlushD && !StallD;

  assign FetchStallF = !(wr_mem || wr_hold || wr_adel || FlushD);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      req_addr   <= 32'h0;
      hold_instr <= 32'h0;
      discard    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (accept) begin
            req_addr <= imem_addr;
            discard  <= FlushD;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            discard <= 1'b0;
            if (!discard && !FlushD && StallD) begin
              hold_instr <= imem_rdata;
              state      <= HOLD;
            end else begin
              state <= REQ;
            end
          end else if (FlushD) begin
            discard <= 1'b1;
          end
        end
        HOLD: begin
          if (FlushD || !StallD) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flush keeps PCPlus4D; only the instruction and valid bit are killed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      InstrD   <= RESET_INSTR;
      PCPlus4D <= 32'h0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= RESET_INSTR;
      ValidD <= 1'b0;
    end else if (wr_mem) begin
      InstrD   <= imem_rdata;
      PCPlus4D <= req_addr + 32'd4;
      ValidD   <= 1'b1;
    end else if (wr_hold) begin
      InstrD   <= hold_instr;
      PCPlus4D <= req_addr + 32'd4;
      ValidD   <= 1'b1;
    end else if (wr_adel) begin
      InstrD   <= RESET_INSTR;
      PCPlus4D <= PCF + 32'd4;
      ValidD   <= 1'b1;
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      AdelD <= 1'b0;
    end else if (FlushD || wr_mem || wr_hold) begin
      AdelD <= 1'b0;
    end else if (wr_adel) begin
      AdelD <= 1'b1;
    end
  end
`else
  assign AdelD = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed + randomized bench for ifetch_unit.
// Random phase checks against a transaction-level fetch model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] PCF = 32'h0;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        FetchStallF;
  logic [31:0] InstrD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        AdelD;

  int checks = 0;
  int failures = 0;

  ifetch_unit dut (
    .clk(clk), .reset_n(reset_n), .PCF(PCF),
    .StallD(StallD), .FlushD(FlushD),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .FetchStallF(FetchStallF),
    .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .AdelD(AdelD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ed;
    @(posedge clk);
    #1;
  endtask

  task automatic half;
    @(negedge clk);
  endtask

  // transaction model state
  bit          m_out, m_kill, m_pend, retire, exp_req, rsp;
  int          m_lat;
  logic [31:0] m_addr, p_instr, e_instr, e_p4, r_instr;
  logic        e_valid;

  initial begin
    // reset
    reset_n = 1'b0;
    ed(); ed();
    chk("rst_instr", InstrD, 32'h0);
    chk("rst_p4", PCPlus4D, 32'h0);
    chk("rst_valid", {31'b0, ValidD}, 32'h0);
    chk("rst_adel", {31'b0, AdelD}, 32'h0);
    reset_n = 1'b1;
    half();
    chk("idle_req", {31'b0, imem_req}, 32'h0);
    chk("idle_stall", {31'b0, FetchStallF}, 32'h1);
    ed();
    // first fetch, zero-wait memory
    PCF = 32'h0; imem_ready = 1'b1;
    half();
    chk("t1_req", {31'b0, imem_req}, 32'h1);
    chk("t1_stall_req", {31'b0, FetchStallF}, 32'h1);
    ed();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h20080005;
    half();
    chk("t1_stall_wait", {31'b0, FetchStallF}, 32'h0);
    ed();
    imem_rvalid = 1'b0;
    chk("t1_instr", InstrD, 32'h20080005);
    chk("t1_p4", PCPlus4D, 32'h4);
    chk("t1_valid", {31'b0, ValidD}, 32'h1);
    // ready held low, PCF moves
    for (int i = 1; i <= 3; i++) begin
      PCF = 32'h100 * i;
      half();
      chk("t2_req", {31'b0, imem_req}, 32'h1);
      chk("t2_stall", {31'b0, FetchStallF}, 32'h1);
      chk("t2_addr", imem_addr, 32'h100 * i);
      ed();
    end
    PCF = 32'h300; imem_ready = 1'b1;
    half();
    ed();
    // stall at response -> hold
    imem_ready = 1'b0; StallD = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hAABBCCDD;
    half();
    chk("t3_stall_rsp", {31'b0, FetchStallF}, 32'h1);
    ed();
    imem_rvalid = 1'b0;
    chk("t3_instr_held", InstrD, 32'h20080005);
    half();
    chk("t3_hold_req", {31'b0, imem_req}, 32'h0);
    chk("t3_hold_stall", {31'b0, FetchStallF}, 32'h1);
    ed();
    StallD = 1'b0;
    half();
    chk("t3_release", {31'b0, FetchStallF}, 32'h0);
    ed();
    chk("t3_instr", InstrD, 32'hAABBCCDD);
    chk("t3_p4", PCPlus4D, 32'h304);
    chk("t3_valid", {31'b0, ValidD}, 32'h1);
    // flush during wait
    PCF = 32'h400; imem_ready = 1'b1;
    half();
    ed();
    imem_ready = 1'b0; FlushD = 1'b1;
    half();
    chk("t4_flush_stall", {31'b0, FetchStallF}, 32'h0);
    ed();
    FlushD = 1'b0;
    chk("t4_valid", {31'b0, ValidD}, 32'h0);
    chk("t4_instr", InstrD, 32'h0);
    chk("t4_p4_kept", PCPlus4D, 32'h304);
    half();
    chk("t4_wait_req", {31'b0, imem_req}, 32'h0);
    ed();
    imem_rvalid = 1'b1; imem_rdata = 32'h12345678; PCF = 32'h800;
    half();
    chk("t4_drop_stall", {31'b0, FetchStallF}, 32'h1);
    ed();
    imem_rvalid = 1'b0;
    chk("t4_drop_valid", {31'b0, ValidD}, 32'h0);
    chk("t4_drop_instr", InstrD, 32'h0);
    imem_ready = 1'b1;
    half();
    chk("t4_new_req", {31'b0, imem_req}, 32'h1);
    chk("t4_new_addr", imem_addr, 32'h800);
    ed();
    // flush beats stall and a same-cycle write
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFEF00D;
    FlushD = 1'b1; StallD = 1'b1;
    half();
    chk("t5_stall", {31'b0, FetchStallF}, 32'h0);
    ed();
    imem_rvalid = 1'b0; FlushD = 1'b0; StallD = 1'b0;
    chk("t5_valid", {31'b0, ValidD}, 32'h0);
    chk("t5_instr", InstrD, 32'h0);
    half();
    chk("t5_req", {31'b0, imem_req}, 32'h1);
    // PCPlus4D wrap
    PCF = 32'hFFFFFFFC; imem_ready = 1'b1;
    half();
    ed();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00000013;
    half();
    ed();
    imem_rvalid = 1'b0;
    chk("t6_p4_wrap", PCPlus4D, 32'h0);
    chk("t6_instr", InstrD, 32'h13);
    // misaligned PCF
    PCF = 32'h6; imem_ready = 1'b1;
`ifdef IFETCH_ALIGN_CHECK_EN
    half();
    chk("t7_req", {31'b0, imem_req}, 32'h0);
    chk("t7_stall", {31'b0, FetchStallF}, 32'h0);
    ed();
    imem_ready = 1'b0;
    chk("t7_adel", {31'b0, AdelD}, 32'h1);
    chk("t7_valid", {31'b0, ValidD}, 32'h1);
    chk("t7_p4", PCPlus4D, 32'hA);
    chk("t7_instr", InstrD, 32'h0);
`else
    half();
    chk("t7_req", {31'b0, imem_req}, 32'h1);
    chk("t7_addr", imem_addr, 32'h4);
    ed();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h55;
    half();
    ed();
    imem_rvalid = 1'b0;
    chk("t7_p4", PCPlus4D, 32'h8);
    chk("t7_adel", {31'b0, AdelD}, 32'h0);
`endif
    // reset mid-wait, late response ignored
    PCF = 32'h20; imem_ready = 1'b1;
    half();
    ed();
    imem_ready = 1'b0; reset_n = 1'b0;
    ed();
    chk("t8_rst_valid", {31'b0, ValidD}, 32'h0);
    chk("t8_rst_p4", PCPlus4D, 32'h0);
    reset_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
    half();
    chk("t8_idle_req", {31'b0, imem_req}, 32'h0);
    chk("t8_idle_stall", {31'b0, FetchStallF}, 32'h1);
    ed();
    half();
    chk("t8_req", {31'b0, imem_req}, 32'h1);
    chk("t8_req_stall", {31'b0, FetchStallF}, 32'h1);
    ed();
    imem_rvalid = 1'b0;
    chk("t8_valid", {31'b0, ValidD}, 32'h0);
    chk("t8_instr", InstrD, 32'h0);
    // randomized phase
    reset_n = 1'b0;
    ed();
    reset_n = 1'b1;
    ed();
    m_out = 0; m_kill = 0; m_pend = 0; m_lat = 0;
    m_addr = 0; p_instr = 0;
    e_instr = 0; e_p4 = 0; e_valid = 0;
    for (int n = 0; n < 600; n++) begin
      StallD = ($urandom_range(0, 3) == 0);
      FlushD = ($urandom_range(0, 9) == 0);
      imem_ready = 1'($urandom_range(0, 1));
      PCF = $urandom;
`ifdef IFETCH_ALIGN_CHECK_EN
      PCF[1:0] = 2'b00;
`endif
      imem_rdata = $urandom;
      imem_rvalid = 1'b0;
      if (m_out) begin
        if (m_lat == 0) imem_rvalid = 1'b1;
        else m_lat--;
      end
      half();
      rsp = imem_rvalid;
      retire = 0;
      r_instr = 32'h0;
      if (rsp && !m_kill && !FlushD && !StallD) begin
        retire = 1; r_instr = imem_rdata;
      end else if (m_pend && !FlushD && !StallD) begin
        retire = 1; r_instr = p_instr;
      end
      exp_req = !m_out && !m_pend;
      chk("r_req", {31'b0, imem_req}, {31'b0, exp_req});
      chk("r_stall", {31'b0, FetchStallF},
          {31'b0, !(retire || FlushD)});
      if (exp_req) chk("r_addr", imem_addr, {PCF[31:2], 2'b00});
      if (m_pend && (FlushD || retire)) m_pend = 0;
      if (FlushD) begin
        e_instr = 32'h0; e_valid = 0;
      end else if (retire) begin
        e_instr = r_instr; e_p4 = m_addr + 32'd4; e_valid = 1;
      end
      if (exp_req && imem_ready) begin
        m_out = 1; m_addr = {PCF[31:2], 2'b00};
        m_kill = FlushD; m_lat = $urandom_range(0, 3);
      end else if (m_out) begin
        if (rsp) begin
          m_out = 0;
          if (!m_kill && !FlushD && StallD) begin
            m_pend = 1; p_instr = imem_rdata;
          end
        end else if (FlushD) begin
          m_kill = 1;
        end
      end
      ed();
      chk("r_instr", InstrD, e_instr);
      chk("r_p4", PCPlus4D, e_p4);
      chk("r_valid", {31'b0, ValidD}, {31'b0, e_valid});
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
